// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode/funct constants, fetch FSM states and jump-target helper
package mips_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'd0;
  localparam logic [5:0] OP_J      = 6'd2;
  localparam logic [5:0] OP_LW     = 6'd35;
  localparam logic [5:0] OP_SW     = 6'd43;
  localparam logic [5:0] FUNCT_ADD = 6'd32;
  localparam logic [5:0] FUNCT_SUB = 6'd34;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DISCARD
  } fetch_state_t;

  function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [31:0] instr);
    logic [31:0] npc;
    npc = pc + PC_STEP;
    return {npc[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory handshake and decode-side instruction stream
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [5:0]  op_code;
  logic [5:0]  funct;
  logic        jump;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, op_code, funct,
    input  imem_ack, imem_rdata, instr_ready, jump
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, op_code, funct,
    output imem_ack, imem_rdata, instr_ready, jump
  );

endinterface

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - small synchronous FIFO of {pc, instr} with flush
module fetch_buffer #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [31:0]              push_instr,
  input  logic [31:0]              push_pc,
  input  logic                     pop,
  input  logic                     flush,
  output logic [31:0]              head_instr,
  output logic [31:0]              head_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      instr_mem <= '{default: '0};
      pc_mem    <= '{default: '0};
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        instr_mem[wr_ptr] <= push_instr;
        pc_mem[wr_ptr]    <= push_pc;
        wr_ptr            <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
    end
  end

  assign head_instr = instr_mem[rd_ptr];
  assign head_pc    = pc_mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner, imem request FSM and jump redirect in front of decode
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_t  state, state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   hold_addr;
  logic [CW-1:0] count;
  logic [31:0]   head_instr;
  logic [31:0]   head_pc;
  logic [31:0]   target;
  logic          valid;
  logic          pop;
  logic          take_jump;
  logic          push;
  logic          req;
  logic [31:0]   addr;

  assign valid     = (count != '0);
  assign pop       = valid && bus.instr_ready;
  assign take_jump = pop && bus.jump;
  assign target    = jump_target(head_pc, head_instr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    addr      = fetch_pc;
    push      = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        req  = (count < CW'(BUF_DEPTH));
        // A jump kills the word returning this cycle; an unanswered request must be drained.
        push = req && bus.imem_ack && !take_jump;
        if (take_jump && req && !bus.imem_ack) begin
          state_nxt = S_DISCARD;
        end
      end
      S_DISCARD: begin
        req  = 1'b1;
        addr = hold_addr;
        if (bus.imem_ack) begin
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      hold_addr <= RESET_PC;
    end else begin
      if (take_jump) begin
        fetch_pc <= target;
      end else if (push) begin
        fetch_pc <= fetch_pc + PC_STEP;
      end
      if (state == S_FETCH && state_nxt == S_DISCARD) begin
        hold_addr <= fetch_pc;
      end
    end
  end

  fetch_buffer #(
    .DEPTH(BUF_DEPTH)
  ) u_buffer (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_instr (bus.imem_rdata),
    .push_pc    (fetch_pc),
    .pop        (pop),
    .flush      (take_jump),
    .head_instr (head_instr),
    .head_pc    (head_pc),
    .count      (count)
  );

  assign bus.imem_req    = req;
  assign bus.imem_addr   = addr;
  assign bus.instr_valid = valid;
  assign bus.instr       = head_instr;
  assign bus.instr_pc    = head_pc;
  assign bus.op_code     = head_instr[31:26];
  assign bus.funct       = head_instr[5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a latency-programmable memory
module tb_fetch_unit;
  import mips_pkg::*;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] addr_log[$];
  logic [31:0] mem_ov[logic [31:0]];
  int          mem_lat = 0;
  int          wait_cnt = 0;
  bit          drop_next = 0;
  bit          pend = 0;
  logic [31:0] pend_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_ov.exists(a)) return mem_ov[a];
    return {OP_LW, 10'd0, a[15:0]};
  endfunction

  // Memory model: answers after mem_lat waiting cycles, records expected buffer pushes.
  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        bus.imem_ack = 1'b0;
        wait_cnt     = 0;
        pend         = 0;
      end else begin
        if (pend) begin
          total++;
          if (bus.imem_req !== 1'b1 || bus.imem_addr !== pend_addr) begin
            bad++;
            $display("FAIL handshake_hold: req=%b addr=%h, required req=1 addr=%h", bus.imem_req, bus.imem_addr, pend_addr);
          end
        end
        if (bus.imem_req === 1'b1) begin
          if (wait_cnt >= mem_lat) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = mem_word(bus.imem_addr);
            addr_log.push_back(bus.imem_addr);
            if (drop_next) drop_next = 0;
            else exp_q.push_back({bus.imem_rdata, bus.imem_addr});
            wait_cnt = 0;
            pend     = 0;
          end else begin
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = 32'hDEAD_BEEF;
            wait_cnt++;
            pend      = 1;
            pend_addr = bus.imem_addr;
          end
        end else begin
          bus.imem_ack   = 1'b0;
          bus.imem_rdata = 32'hDEAD_BEEF;
          pend           = 0;
        end
      end
    end
  end

  // Scoreboard: every accepted head must match the next expected word.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst && bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pop: instr=%h pc=%h, required no valid head", bus.instr, bus.instr_pc);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.instr !== mon_e.instr || bus.instr_pc !== mon_e.pc ||
              bus.op_code !== mon_e.instr[31:26] || bus.funct !== mon_e.instr[5:0]) begin
            bad++;
            $display("FAIL head: instr=%h pc=%h op=%0d funct=%0d, required instr=%h pc=%h", bus.instr, bus.instr_pc, bus.op_code, bus.funct, mon_e.instr, mon_e.pc);
          end
        end
        if (bus.jump === 1'b1) begin
          exp_q.delete();
          if (bus.imem_req === 1'b1 && bus.imem_ack !== 1'b1) drop_next = 1;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.instr_ready = 1'b0;
    bus.jump = 1'b0;
    step();
    step();
    exp_q.delete();
    addr_log.delete();
    mem_ov.delete();
    drop_next = 0;
  endtask

  task automatic test_reset();
    step();
    step();
    total += 7;
    if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: %b, required 0", bus.imem_req); end
    if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: %h, required 0", bus.imem_addr); end
    if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: %b, required 0", bus.instr_valid); end
    if (bus.instr !== 32'h0) begin bad++; $display("FAIL rst_instr: %h, required 0", bus.instr); end
    if (bus.instr_pc !== 32'h0) begin bad++; $display("FAIL rst_pc: %h, required 0", bus.instr_pc); end
    if (bus.op_code !== 6'h0) begin bad++; $display("FAIL rst_op: %h, required 0", bus.op_code); end
    if (bus.funct !== 6'h0) begin bad++; $display("FAIL rst_funct: %h, required 0", bus.funct); end
  endtask

  task automatic test_stream();
    bit found = 0;
    do_reset();
    mem_lat = 0;
    bus.instr_ready = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (bus.imem_ack === 1'b1) found = 1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL stream_first_ack: ack=0 for 10 cycles, required ack within 10 cycles"); end
    total++;
    if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL stream_valid_early: %b, required 0", bus.instr_valid); end
    step();
    total++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) begin
      bad++; $display("FAIL stream_first_head: valid=%b pc=%h, required 1 and 0", bus.instr_valid, bus.instr_pc);
    end
    repeat (4) step();
    bus.instr_ready = 1'b0;
    total++;
    if (addr_log.size() < 4) begin
      bad++; $display("FAIL stream_addr_count: %0d, required at least 4", addr_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (addr_log[i] !== 32'(i * 4)) begin
          bad++; $display("FAIL stream_addr%0d: %h, required %h", i, addr_log[i], 32'(i * 4));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mem_lat = 0;
    rst = 1'b0;
    repeat (8) step();
    total += 3;
    if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL bp_req_full: %b, required 0", bus.imem_req); end
    if (addr_log.size() != 2) begin bad++; $display("FAIL bp_words: %0d, required 2", addr_log.size()); end
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) begin
      bad++; $display("FAIL bp_head: valid=%b pc=%h, required 1 and 0", bus.instr_valid, bus.instr_pc);
    end
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    total++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin
      bad++; $display("FAIL bp_resume: req=%b addr=%h, required 1 and 8", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic wait_jump_at(input logic [31:0] pc, input int budget);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      step();
      if (bus.instr_valid === 1'b1 && bus.instr_pc === pc) begin
        bus.jump = 1'b1;
        hit = 1;
      end
    end
    total++;
    if (!hit) begin bad++; $display("FAIL jump_head: pc %h never at head, required within %0d cycles", pc, budget); end
  endtask

  task automatic test_jump();
    do_reset();
    mem_ov[32'h8] = 32'h0800_0010;
    mem_lat = 0;
    bus.instr_ready = 1'b1;
    rst = 1'b0;
    wait_jump_at(32'h8, 20);
    step();
    bus.jump = 1'b0;
    total++;
    if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin
      bad++; $display("FAIL jump_redirect: valid=%b req=%b addr=%h, required 0 1 00000040", bus.instr_valid, bus.imem_req, bus.imem_addr);
    end
    step();
    total++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h40) begin
      bad++; $display("FAIL jump_target_head: valid=%b pc=%h, required 1 and 00000040", bus.instr_valid, bus.instr_pc);
    end
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_discard();
    bit found = 0;
    do_reset();
    mem_ov[32'h8] = 32'h0800_0010;
    mem_lat = 3;
    bus.instr_ready = 1'b1;
    rst = 1'b0;
    wait_jump_at(32'h8, 60);
    for (int i = 0; i < 3; i++) begin
      step();
      bus.jump = 1'b0;
      total++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC || bus.instr_valid !== 1'b0) begin
        bad++; $display("FAIL discard_hold%0d: req=%b addr=%h valid=%b, required 1 0000000c 0", i, bus.imem_req, bus.imem_addr, bus.instr_valid);
      end
    end
    step();
    total++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin
      bad++; $display("FAIL discard_next_req: req=%b addr=%h, required 1 00000040", bus.imem_req, bus.imem_addr);
    end
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (bus.instr_valid === 1'b1) found = 1;
    end
    total++;
    if (!found || bus.instr_pc !== 32'h40) begin
      bad++; $display("FAIL discard_first_head: found=%b pc=%h, required 1 and 00000040", found, bus.instr_pc);
    end
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    do_reset();
    mem_lat = 3;
    rst = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (bus.instr_valid === 1'b1) found = 1;
    end
    total++;
    if (!found || bus.imem_req !== 1'b1) begin
      bad++; $display("FAIL midrst_setup: valid=%b req=%b, required 1 1", found, bus.imem_req);
    end
    rst = 1'b1;
    #1;
    exp_q.delete();
    drop_next = 0;
    total++;
    if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0 || bus.instr_valid !== 1'b0 ||
        bus.instr !== 32'h0 || bus.instr_pc !== 32'h0) begin
      bad++; $display("FAIL midrst_outputs: req=%b addr=%h valid=%b instr=%h pc=%h, required all 0", bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr, bus.instr_pc);
    end
    step();
    rst = 1'b0;
    step();
    total++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      bad++; $display("FAIL midrst_restart: req=%b addr=%h, required 1 00000000", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_decode();
    do_reset();
    mem_ov[32'h0] = 32'h8C22_0004;
    mem_ov[32'h4] = 32'h0022_1820;
    mem_lat = 0;
    rst = 1'b0;
    repeat (5) step();
    total++;
    if (bus.op_code !== OP_LW || bus.funct !== 6'h04 || bus.instr !== 32'h8C22_0004) begin
      bad++; $display("FAIL decode_lw: op=%0d funct=%0d instr=%h, required 35 4 8c220004", bus.op_code, bus.funct, bus.instr);
    end
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    step();
    total++;
    if (bus.op_code !== OP_RTYPE || bus.funct !== FUNCT_ADD || bus.instr_pc !== 32'h4) begin
      bad++; $display("FAIL decode_add: op=%0d funct=%0d pc=%h, required 0 32 00000004", bus.op_code, bus.funct, bus.instr_pc);
    end
  endtask

  initial begin
    bus.instr_ready = 1'b0;
    bus.jump = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_jump();
    test_discard();
    test_reset_mid();
    test_decode();
    do_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
